// File: rtl/maze_lookup_arbiter.sv
// Single-port maze tile RAM arbiter: round-robin sprite reads, streak-limited
// flush writes, and a fixed-latency tagged response pipeline.
module maze_lookup_arbiter #(
    parameter int N_REQ         = 5,
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 4,
    parameter int MEM_LAT       = 1,
    parameter int MAX_WR_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        rd_req,
    input  logic [N_REQ*ADDR_W-1:0] rd_addr,
    output logic [N_REQ-1:0]        rd_gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_gnt,
    input  logic                    hold,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STK_W = $clog2(MAX_WR_STREAK + 1);

    // Handshake: a request completes in the cycle where req and gnt are both
    // high; the requester holds req/addr stable until then.

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [STK_W-1:0]  wr_streak;
    logic [N_REQ-1:0]  tag_q [MEM_LAT];

    logic              any_rd;
    logic              wr_win;
    logic [N_REQ-1:0]  ge_mask;
    logic [N_REQ-1:0]  masked;
    logic [N_REQ-1:0]  rr_pick;
    logic [ADDR_W-1:0] rd_addr_sel;

    assign any_rd = |rd_req;

    // Requests at or above rr_ptr win first; otherwise wrap to the lowest set bit.
    assign ge_mask = ~((N_REQ'(1) << rr_ptr) - N_REQ'(1));
    assign masked  = rd_req & ge_mask;
    assign rr_pick = (|masked) ? (masked & (~masked + N_REQ'(1)))
                               : (rd_req & (~rd_req + N_REQ'(1)));

    assign wr_win = wr_req && (!any_rd || (wr_streak < STK_W'(MAX_WR_STREAK)));
    assign wr_gnt = !hold && wr_win;
    assign rd_gnt = (!hold && !wr_win) ? rr_pick : '0;

    always_comb begin
        rd_addr_sel = '0;
        ptr_next    = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (rd_gnt[i]) begin
                rd_addr_sel = rd_addr[i*ADDR_W +: ADDR_W];
                ptr_next    = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign mem_en    = wr_gnt | (|rd_gnt);
    assign mem_we    = wr_gnt;
    assign mem_addr  = wr_gnt ? wr_addr : rd_addr_sel;
    assign mem_wdata = wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            wr_streak <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            if (|rd_gnt) rr_ptr <= ptr_next;

            if (!hold) begin
                if ((|rd_gnt) || !any_rd)
                    wr_streak <= '0;
                else if (wr_gnt && (wr_streak != STK_W'(MAX_WR_STREAK)))
                    wr_streak <= wr_streak + STK_W'(1);
            end

            // Tag tracks which requester owns the RAM data emerging MEM_LAT cycles later.
            tag_q[0] <= rd_gnt;
            for (int i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];

            rsp_valid <= tag_q[MEM_LAT-1];
            if (|tag_q[MEM_LAT-1]) rsp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Bench for maze_lookup_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbitration/response model.
module tb_maze_lookup_arbiter;

    localparam int N    = 5;
    localparam int AW   = 10;
    localparam int DW   = 4;
    localparam int MAXS = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    rd_req;
    logic [N*AW-1:0] rd_addr;
    logic [N-1:0]    rd_gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_gnt;
    logic            hold;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    maze_lookup_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_WR_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .hold(hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tile RAM with one cycle of read latency
    logic [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: reference arbiter state and expected response queue
    int           m_ptr    = 0;
    int           m_streak = 0;
    logic [8:0]   exp_q[$];
    logic [N-1:0] gnt_seen = '0;
    logic         wr_seen  = 1'b0;

    always @(negedge clk) begin : model
        int           e_idx;
        logic         e_wr;
        logic [N-1:0] e_rd;
        logic [AW-1:0] e_addr;
        logic [8:0]   e_rsp;
        if (rst) begin
            m_ptr = 0;
            m_streak = 0;
            exp_q.delete();
            exp_q.push_back(9'h0);
            exp_q.push_back(9'h0);
        end
        e_wr = 1'b0; e_rd = '0; e_idx = -1; e_addr = '0;
        if (!hold) begin
            if (wr_req && (rd_req == '0 || m_streak < MAXS)) e_wr = 1'b1;
            else
                for (int k = 0; k < N; k++)
                    if (e_idx < 0 && |(rd_req & (N'(1) << ((m_ptr + k) % N))))
                        e_idx = (m_ptr + k) % N;
        end
        if (e_idx >= 0) begin
            e_rd   = N'(1) << e_idx;
            e_addr = AW'(rd_addr >> (e_idx * AW));
        end
        if (e_wr) e_addr = wr_addr;

        check_eq("m_rd_gnt", 32'(rd_gnt), 32'(e_rd));
        check_eq("m_wr_gnt", 32'(wr_gnt), 32'(e_wr));
        check_eq("m_mem_en", 32'(mem_en), 32'(e_wr || e_idx >= 0));
        check_eq("m_mem_we", 32'(mem_we), 32'(e_wr));
        check_eq("m_mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_wr) check_eq("m_mem_wdata", 32'(mem_wdata), 32'(wr_data));

        if (rst) begin
            check_eq("m_rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check_eq("m_rst_rsp_data", 32'(rsp_data), 32'h0);
        end else begin
            e_rsp = exp_q.pop_front();
            check_eq("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp[8:4]));
            if (e_rsp[8:4] != '0) check_eq("m_rsp_data", 32'(rsp_data), 32'(e_rsp[3:0]));
            exp_q.push_back((e_idx >= 0) ? {e_rd, ram[e_addr]} : 9'h0);
            if (!hold) begin
                if (e_idx >= 0) begin
                    m_ptr = (e_idx + 1) % N;
                    m_streak = 0;
                end else if (rd_req == '0) m_streak = 0;
                else if (e_wr) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            end
        end
        gnt_seen = rd_gnt;
        wr_seen  = wr_gnt;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_req = '0; wr_req = 1'b0; hold = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_slice(input int i, input logic [AW-1:0] a);
        logic [N*AW-1:0] m;
        m = (N*AW)'({AW{1'b1}}) << (i * AW);
        rd_addr = (rd_addr & ~m) | ((N*AW)'(a) << (i * AW));
    endtask

    initial begin
        logic [N-1:0] bm;
        rst = 1'b1; rd_req = '0; rd_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; hold = 1'b0;
        foreach (ram[i]) ram[i] = DW'($urandom);

        // reset state
        @(negedge clk);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("reset_rsp_data", 32'(rsp_data), 32'h0);
        check_eq("reset_mem_en", 32'(mem_en), 32'h0);

        // single read from requester 2
        do_reset();
        ram[10'h155] = 4'hA;
        rd_req = 5'b00100;
        set_slice(2, 10'h155);
        @(negedge clk);
        check_eq("single_gnt", 32'(rd_gnt), 32'h04);
        check_eq("single_addr", 32'(mem_addr), 32'h155);
        step(); rd_req = '0;
        @(negedge clk);
        check_eq("single_rsp_early", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        check_eq("single_rsp_valid", 32'(rsp_valid), 32'h04);
        check_eq("single_rsp_data", 32'(rsp_data), 32'hA);
        step(); rd_req = 5'b11111;
        @(negedge clk);
        check_eq("single_ptr_next", 32'(rd_gnt), 32'h08);
        step(); rd_req = '0;

        // fairness with all requesters active
        do_reset();
        rd_req = 5'b11111;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) rd_req = '0;
            @(negedge clk);
            if (k < 10) check_eq("fair_gnt", 32'(rd_gnt), 32'(N'(1) << (k % N)));
            if (k >= 2) check_eq("fair_rsp", 32'(rsp_valid), 32'(N'(1) << ((k - 2) % N)));
            step();
        end

        // wrap-around from pointer 4
        do_reset();
        rd_req = 5'b01000;
        @(negedge clk);
        step();
        rd_req = 5'b10001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("wrap_gnt", 32'(rd_gnt), (k == 1) ? 32'h01 : 32'h10);
            step();
        end
        rd_req = '0;

        // write priority bounded by the streak limit
        do_reset();
        wr_req = 1'b1; wr_addr = 10'h2C3; wr_data = 4'h7;
        rd_req = 5'b00010;
        set_slice(1, 10'h011);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check_eq("streak_wr", 32'(wr_gnt), 32'(k != 4));
            check_eq("streak_rd", 32'(rd_gnt), (k == 4) ? 32'h02 : 32'h0);
            step();
            if (k == 4) rd_req = '0;
        end
        wr_req = 1'b0;

        // hold blocks grants, in-flight read still answers
        do_reset();
        rd_req = 5'b01000;
        set_slice(3, 10'h0F0);
        @(negedge clk);
        check_eq("hold_first", 32'(rd_gnt), 32'h08);
        step(); hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_no_gnt", 32'(rd_gnt), 32'h0);
            check_eq("hold_no_en", 32'(mem_en), 32'h0);
            if (k == 1) check_eq("hold_rsp", 32'(rsp_valid), 32'h08);
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        check_eq("hold_release", 32'(rd_gnt), 32'h08);
        step(); rd_req = '0;

        // reset while a read is in flight
        do_reset();
        rd_req = 5'b00001;
        @(negedge clk);
        check_eq("mf_gnt", 32'(rd_gnt), 32'h01);
        step(); rst = 1'b1; rd_req = '0;
        @(negedge clk);
        check_eq("mf_rsp_t1", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        check_eq("mf_rsp_t2", 32'(rsp_valid), 32'h0);
        step(); rst = 1'b0; rd_req = 5'b11111;
        @(negedge clk);
        check_eq("mf_ptr_zero", 32'(rd_gnt), 32'h01);
        check_eq("mf_rsp_t3", 32'(rsp_valid), 32'h0);
        step(); rd_req = '0;

        // randomized traffic, requests held until granted
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                bm = N'(1) << i;
                if ((rd_req & bm) == '0 || (gnt_seen & bm) != '0) begin
                    if ($urandom_range(0, 99) < 40) rd_req = rd_req | bm;
                    else rd_req = rd_req & ~bm;
                    set_slice(i, AW'($urandom));
                end
            end
            if (!wr_req || wr_seen) begin
                wr_req  = ($urandom_range(0, 99) < 35);
                wr_addr = AW'($urandom);
                wr_data = DW'($urandom);
            end
            hold = ($urandom_range(0, 99) < 10);
            rst  = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; rd_req = '0; wr_req = 1'b0; hold = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_lookup_arbiter.md
# maze_lookup_arbiter

Shares the single port of the maze tile RAM among the per-sprite position-update requesters (pacman, blinky, pinky, inky, clyde) and the eaten-food flush writer. Read requests are served round-robin, one per cycle, with a fixed-latency response pipeline. Writes take priority, bounded by a streak limit so that no read starves. Sits between the sprite update logic in the game-logic top level and the maze tile memory.

## Interface
- N_REQ, 5, number of read requesters; index 0 = pacman, 1..4 = ghosts in sprite order
- ADDR_W, 10, tile address width
- DATA_W, 4, tile code width
- MEM_LAT, 1, fixed RAM read latency in cycles (≥1)
- MAX_WR_STREAK, 4, maximum consecutive write grants while any read is pending (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rd_req  in  N_REQ  per-requester read request; held until granted
- rd_addr  in  N_REQ*ADDR_W  flattened addresses; slice i = bits [i*ADDR_W +: ADDR_W]
- rd_gnt  out  N_REQ  one-hot-or-zero, combinational, same cycle as accepted request
- rsp_valid  out  N_REQ  one-hot-or-zero, registered, one-cycle pulse
- rsp_data  out  DATA_W  tile code, valid only when rsp_valid ≠ 0
- wr_req  in  1  flush write request; held until granted
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  combinational write accept
- hold  in  1  when high, no new grants of either type; in-flight reads still complete
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after a read strobe

## Operation
- Each cycle, at most one grant: wr_gnt or exactly one rd_gnt bit, never both.
- A handshake completes in the cycle where req and gnt are both high. The requester drops or changes its req/addr on the following cycle.
- Grant selection (hold=0):
  - Write is granted when wr_req=1 and either no rd_req bit is set or wr_streak < MAX_WR_STREAK.
  - Otherwise, if any rd_req bit is set, grant the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
- hold=1 forces rd_gnt=0, wr_gnt=0, mem_en=0. Pointers and counters are unchanged.
- mem_en = |rd_gnt | wr_gnt.
  - mem_we = wr_gnt.
  - mem_addr = wr_addr on a write, otherwise the granted slice of rd_addr.
  - mem_wdata = wr_data; its value is don't-care unless mem_we=1.
  - When mem_en=0, mem_addr and mem_we are 0.
- rr_ptr (width clog2(N_REQ)):
  - After a read grant to index i: rr_ptr ← (i+1) mod N_REQ, wrapping N_REQ−1 → 0.
  - Unchanged on write grants and idle cycles.
- wr_streak (saturating, range 0..MAX_WR_STREAK):
  - +1 on each write grant.
  - Cleared on each read grant.
  - Cleared on any cycle with no rd_req set.
- Response pipeline:
  - A read grant pushes its one-hot index into a tag shift register of depth MEM_LAT.
  - When a tag exits, rsp_valid ← tag and rsp_data ← mem_rdata, both registered.
  - Writes and idle cycles push a zero tag.
- Reset, including mid-operation:
  - rr_ptr=0, wr_streak=0, tag pipeline cleared.
  - rsp_valid=0, rsp_data=0.
  - In-flight reads are dropped with no response. Requesters re-issue after reset.

## Timing
- Grant latency: 0 cycles (combinational from rd_req, wr_req, hold, and registered state).
- Read response: rsp_valid rises exactly MEM_LAT+1 clock edges after the granting edge. With MEM_LAT=1, a grant in cycle t gives its response in cycle t+2.
- Throughput: one access per cycle. Back-to-back reads yield back-to-back rsp_valid pulses.
- Responses return in grant order. No two rsp_valid bits are ever set together.
- Worst-case read wait with all requesters active and writes saturating:
  - A pending read wins one grant slot within MAX_WR_STREAK+1 cycles.
  - A specific requester is granted within N_REQ·(MAX_WR_STREAK+1) cycles.
- Reset outputs: rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata reflect inputs combinationally with zeroed state. rsp_valid=0, rsp_data=0.

## Test plan
- Single read: rd_req=5'b00100, addr slice 2 = 10'h155, mem returns 4'hA.
  - Expect rd_gnt=5'b00100 and mem_addr=10'h155 in cycle t.
  - Expect rsp_valid=5'b00100 and rsp_data=4'hA in cycle t+2.
  - rr_ptr becomes 3.
- Fairness: rd_req=5'b11111 held for 10 cycles after reset.
  - Expect grant order 0,1,2,3,4,0,1,2,3,4.
  - Expect 10 consecutive rsp_valid pulses in the same order.
- Wrap-around: rr_ptr=4 and rd_req=5'b10001.
  - Expect grant to 4, then 0, then 4.
- Write priority and streak: wr_req=1 continuously and rd_req=5'b00010.
  - Expect wr_gnt for 4 cycles, then rd_gnt=5'b00010 once, then write grants resume.
  - With rd_req=0, expect writes every cycle.
- hold: assert hold=1 one cycle after a read grant, with rd_req=5'b01000.
  - Expect no grants while hold is high.
  - Expect the in-flight rsp_valid still delivered.
  - Expect the grant to requester 3 on the first cycle after hold drops.
- Reset mid-flight: assert rst one cycle after a read grant.
  - Expect rsp_valid to stay 0 for that read.
  - Expect rr_ptr=0 after release.
